// File: rtl/sfilt_pkg.sv
// Shared constants for the sfilt command sequencer: command codes, FSM states, watchdog length.
package sfilt_pkg;

    localparam logic [1:0] CMD_FIRST = 2'd0;
    localparam logic [1:0] CMD_MAC   = 2'd1;
    localparam logic [1:0] CMD_SHIFT = 2'd2;
    localparam logic [1:0] CMD_OUT   = 2'd3;

    localparam int TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/sfilt_tapline.sv
// Circular sample delay line plus coefficient bank, with a combinational read of tap k
// (sample k positions older than the newest, and coefficient k).
module sfilt_tapline #(
    parameter int NTAPS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        smp_we_i,
    input  logic [31:0] smp_data_i,
    input  logic        coef_we_i,
    input  logic [4:0]  coef_addr_i,
    input  logic [31:0] coef_data_i,
    input  logic [5:0]  tap_k_i,
    output logic [31:0] tap_x_o,
    output logic [31:0] tap_c_o
);

    logic [31:0] line_q [NTAPS];
    logic [31:0] coef_q [NTAPS];
    logic [5:0]  wp_q;
    logic [6:0]  rd_sum;
    logic [6:0]  rd_idx;

    // Newest sample sits one slot behind the write pointer.
    always_comb begin
        rd_sum  = {1'b0, wp_q} + 7'(NTAPS - 1) - {1'b0, tap_k_i};
        rd_idx  = (rd_sum >= 7'(NTAPS)) ? rd_sum - 7'(NTAPS) : rd_sum;
        tap_x_o = '0;
        tap_c_o = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (rd_idx == 7'(i)) tap_x_o = line_q[i];
            if (tap_k_i == 6'(i)) tap_c_o = coef_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                line_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            if (smp_we_i) begin
                for (int i = 0; i < NTAPS; i++) begin
                    if (wp_q == 6'(i)) line_q[i] <= smp_data_i;
                end
                wp_q <= (wp_q == 6'(NTAPS - 1)) ? 6'd0 : wp_q + 6'd1;
            end
            if (coef_we_i) begin
                for (int i = 0; i < NTAPS; i++) begin
                    if (coef_addr_i == 5'(i)) coef_q[i] <= coef_data_i;
                end
            end
        end
    end

endmodule

// File: rtl/sfilt_drv.sv
// Sequencer issuing first/mac/shift/out commands to sfilt per sample and returning its result.
// Optional watchdog in WAIT when SFILT_DRV_TIMEOUT_EN is defined.
//   state | meaning
//   IDLE  | ready for a sample; coefficient writes allowed
//   ISSUE | streaming NTAPS+2 commands to the filter
//   WAIT  | waiting for the filter result
module sfilt_drv
    import sfilt_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int SHIFT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_push,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        coef_we,
    input  logic [4:0]  coef_addr,
    input  logic [31:0] coef_data,
    output logic        f_pushin,
    output logic [1:0]  f_cmd,
    output logic [31:0] f_q,
    output logic [31:0] f_h,
    input  logic        f_pushout,
    input  logic [31:0] f_z,
    output logic        out_push,
    output logic [31:0] out_data,
    output logic        err
);

    state_e      state_q;
    logic [5:0]  step_q;
    logic        pushin_q;
    logic [1:0]  cmd_q;
    logic [31:0] q_q;
    logic [31:0] h_q;
    logic        out_push_q;
    logic [31:0] out_data_q;
    logic        in_ready_q;
    logic        pend_we_q;
    logic [4:0]  pend_addr_q;
    logic [31:0] pend_data_q;

    logic        coef_ok;
    logic        smp_we;
    logic        tl_we;
    logic [4:0]  tl_addr;
    logic [31:0] tl_data;
    logic [5:0]  tap_k;
    logic [31:0] tap_x;
    logic [31:0] tap_c;

    // A coefficient write arriving with a sample is held back until that sample's
    // commands have all been issued, so it cannot leak into its own computation.
    always_comb begin
        coef_ok = coef_we && ({1'b0, coef_addr} < 6'(NTAPS));
        smp_we  = (state_q == IDLE) && in_push;
        tap_k   = (state_q == ISSUE) ? step_q + 6'd1 : 6'd0;
        tl_we   = 1'b0;
        tl_addr = coef_addr;
        tl_data = coef_data;
        if (state_q == ISSUE && step_q == 6'(NTAPS + 1) && pend_we_q) begin
            tl_we   = 1'b1;
            tl_addr = pend_addr_q;
            tl_data = pend_data_q;
        end else if (state_q == IDLE && coef_ok && !in_push) begin
            tl_we = 1'b1;
        end
    end

    sfilt_tapline #(.NTAPS(NTAPS)) u_tapline (
        .clk         (clk),
        .rst         (rst),
        .smp_we_i    (smp_we),
        .smp_data_i  (in_data),
        .coef_we_i   (tl_we),
        .coef_addr_i (tl_addr),
        .coef_data_i (tl_data),
        .tap_k_i     (tap_k),
        .tap_x_o     (tap_x),
        .tap_c_o     (tap_c)
    );

`ifdef SFILT_DRV_TIMEOUT_EN
    logic [4:0] wd_q;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Command registers are loaded with the step about to be presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            pushin_q    <= 1'b0;
            cmd_q       <= '0;
            q_q         <= '0;
            h_q         <= '0;
            out_push_q  <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            pend_we_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
`ifdef SFILT_DRV_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            out_push_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_push) begin
                        state_q    <= ISSUE;
                        in_ready_q <= 1'b0;
                        step_q     <= '0;
                        pushin_q   <= 1'b1;
                        cmd_q      <= CMD_FIRST;
                        q_q        <= in_data;
                        h_q        <= tap_c;
                        if (coef_ok) begin
                            pend_we_q   <= 1'b1;
                            pend_addr_q <= coef_addr;
                            pend_data_q <= coef_data;
                        end
                    end
                end
                ISSUE: begin
                    step_q <= step_q + 6'd1;
                    if (step_q + 6'd1 < 6'(NTAPS)) begin
                        cmd_q <= CMD_MAC;
                        q_q   <= tap_x;
                        h_q   <= tap_c;
                    end else if (step_q + 6'd1 == 6'(NTAPS)) begin
                        cmd_q <= CMD_SHIFT;
                        q_q   <= '0;
                        h_q   <= {25'd0, 7'(SHIFT)};
                    end else if (step_q + 6'd1 == 6'(NTAPS + 1)) begin
                        cmd_q <= CMD_OUT;
                        q_q   <= '0;
                        h_q   <= '0;
                    end else begin
                        pushin_q  <= 1'b0;
                        cmd_q     <= '0;
                        q_q       <= '0;
                        h_q       <= '0;
                        pend_we_q <= 1'b0;
                        state_q   <= WAIT;
`ifdef SFILT_DRV_TIMEOUT_EN
                        wd_q      <= 5'(TIMEOUT_CYC - 1);
`endif
                    end
                end
                WAIT: begin
                    if (f_pushout) begin
                        out_push_q <= 1'b1;
                        out_data_q <= f_z;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
`ifdef SFILT_DRV_TIMEOUT_EN
                    else if (wd_q == 5'd0) begin
                        err_q      <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        wd_q <= wd_q - 5'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign f_pushin = pushin_q;
    assign f_cmd    = cmd_q;
    assign f_q      = q_q;
    assign f_h      = h_q;
    assign out_push = out_push_q;
    assign out_data = out_data_q;

endmodule

// File: doc/sfilt_drv.md
# sfilt_drv

Command sequencer that drives a serial filter (`sfilt`) to compute one NTAPS-tap FIR output per input sample. It holds the sample delay line and coefficient bank. For each sample it issues the filter command stream: first-mult, then mult-accumulates, then shift/round, then send-and-clear. It captures the filter's result and returns it on a push-style output. It sits between the sample source and the `sfilt` instance, as the initiator end of the filter's cmd/q/h interface.

## Interface
Parameters:
- `NTAPS`, 8: number of taps, 2..32.
- `SHIFT`, 15: right-shift amount (0..127) sent in `f_h[6:0]` with the shift/round command.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_push`  in  1  sample valid.
- `in_data`  in  32  signed sample.
- `in_ready`  out  1  block can accept a sample this cycle.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  5  tap index.
- `coef_data`  in  32  signed coefficient.
- `f_pushin`  out  1  command valid to filter.
- `f_cmd`  out  2  filter command code.
- `f_q`  out  32  sample operand.
- `f_h`  out  32  coefficient operand, or shift amount.
- `f_pushout`  in  1  filter result valid.
- `f_z`  in  32  filter result.
- `out_push`  out  1  one-cycle result strobe.
- `out_data`  out  32  filter result.
- `err`  out  1  sticky timeout flag; see Configuration.

## Operation
- **Reset:** all outputs are 0, except `in_ready`, which is 1. Delay line is cleared to 0, coefficients are cleared to 0, write pointer is 0, state is IDLE.
- **States:**
  - IDLE: `in_ready`=1.
  - ISSUE: `in_ready`=0.
  - WAIT: `in_ready`=0.
- **IDLE → ISSUE:** on `in_push`. `in_data` is written at the write pointer, which then advances modulo NTAPS (NTAPS-1 wraps to 0). Tap k reads the sample k positions older than the newest one.
- **ISSUE:** `f_pushin`=1 for exactly NTAPS+2 consecutive cycles, in this order:
  - step 0: cmd 0, q = x[n], h = c[0].
  - steps 1..NTAPS-1: cmd 1, q = x[n-k], h = c[k].
  - step NTAPS: cmd 2, q = 0, h = SHIFT.
  - step NTAPS+1: cmd 3, q = 0, h = 0.
- **ISSUE → WAIT:** after the cmd 3 step.
- **WAIT → IDLE:** when `f_pushout` is sampled high. `f_z` is registered into `out_data` and `out_push` pulses for 1 cycle.
- **Arithmetic:** this block does none. The filter does the multiplication, accumulation and rounding. `out_data` is `f_z` unmodified.
- **Coefficient writes:** accepted only in IDLE with `coef_addr` < NTAPS. Writes made in other states, or to out-of-range addresses, are ignored.
- **Boundary cases:**
  - `in_push` while `in_ready`=0: the sample is dropped, with no state change.
  - `f_pushout` outside WAIT: ignored.
  - `in_push` and `coef_we` together in IDLE: both take effect. The new coefficient is not visible to this sample's computation.
  - `rst` mid-ISSUE or mid-WAIT: immediate return to reset state, and `f_pushin` drops in the next cycle. The filter's next computation starts with cmd 0, which overwrites any partial accumulator.

## Timing
- All outputs are registered.
- Sample accepted at edge E: cmd 0 is presented in the cycle after E. The last cmd 3 is presented NTAPS+1 cycles later.
- With `sfilt` latency, `f_pushout` rises 2 cycles after cmd 3 is sampled.
- `out_push` rises 1 cycle after `f_pushout` is sampled. `in_ready` rises in the same cycle as `out_push`.
- Throughput: one sample per NTAPS+5 cycles.

## Configuration
- `SFILT_DRV_TIMEOUT_EN` defined:
  - A 5-bit watchdog runs in WAIT.
  - If `f_pushout` has not been seen after 16 cycles, `err` is set and the state returns to IDLE, with no `out_push`.
  - `err` stays set until `rst`.
- Macro not defined: no watchdog, `err` is tied to 0, and WAIT lasts indefinitely.

## Structure
- Shared package `sfilt_pkg` holds:
  - command constants: CMD_FIRST=0, CMD_MAC=1, CMD_SHIFT=2, CMD_OUT=3.
  - the state enum: IDLE, ISSUE, WAIT.
  - the timeout constant: 16.
- One sub-module, `sfilt_tapline`. It contains the circular delay line, the write pointer, and the coefficient bank. It provides a combinational read of the sample/coefficient pair for tap index k. The FSM and step counter stay in `sfilt_drv`.

## Test plan
All scenarios use `NTAPS`=4 and a real `sfilt` instance.
- **Running sum:** SHIFT=0, coefficients 1,1,1,1, samples 1,2,3,4 → `out_data` = 1, 3, 6, 10.
- **Impulse response:** SHIFT=0, coefficients 5,-3,7,2, samples 1,0,0,0 → outputs 5, -3, 7, 2. Each cmd sequence is exactly 0,1,1,1,2,3 with `f_pushin` held high for 6 contiguous cycles.
- **Rounding:** SHIFT=1, coefficients 1,0,0,0, sample 3 → output 2. Next sample -3 → output -1.
- **Drop and ignore:** `in_push` of 9 during ISSUE is dropped, and the next output reflects the old samples only. A `coef_we` during WAIT leaves the coefficient unchanged.
- **Reset mid-operation:** `rst` during the ISSUE of sample 7, then sample 1 with coefficients 1,1,1,1 → output 1. The delay line was cleared by the reset.
- **Timeout (macro on):** hold `f_pushout` at 0 → `err` rises 16 cycles into WAIT and `in_ready` returns to 1. No `out_push` occurs. `err` clears only on `rst`.
